// File: rtl/adc_spi_pkg.sv
// Shared types and fixed frame geometry for the serial ADC read master.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_QUIET = 2'd2
  } adc_state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_BITS  = 4;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: sclk toggles every HALF_DIV enabled clk cycles,
// starting from the high idle level; ticks flag the edge being made.
module adc_sclk_gen #(
  parameter int HALF_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = 8;

  logic [CW-1:0] cnt;
  logic          term;

  assign term      = en && (cnt == CW'(HALF_DIV - 1));
  assign rise_tick = term && !sclk;
  assign fall_tick = term && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (clr) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (en) begin
      if (term) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI read master for a 12-bit serial ADC: one 16-bit frame per start.
// Define ADC_FRAME_CHECK_EN to flag frames whose 4 leading bits are not zero.
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int HALF_DIV     = 16,
  parameter int QUIET_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 frame_err,
  output adc_state_e           state_dbg
);

  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  adc_state_e            state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [FRAME_BITS-2:0] shift_q;
  logic [FRAME_BITS-1:0] shift_next;
  logic [QW-1:0]         quiet_cnt;
  logic                  pending;
  logic                  rise_tick;
  logic                  fall_tick_unused;
  logic                  frame_done;
  logic                  quiet_done;

  assign state_dbg  = state;
  assign shift_next = {shift_q, sdata};
  assign frame_done = (state == ST_CONV) && rise_tick &&
                      (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  assign quiet_done = (quiet_cnt == QW'(QUIET_CYCLES - 1));

  adc_sclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ST_CONV),
    .clr       (state != ST_CONV),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick_unused)
  );

  // cs_n and busy are registered here; sclk comes registered from the generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      pending      <= 1'b0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      quiet_cnt    <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || pending) begin
            state   <= ST_CONV;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            pending <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_CONV: begin
          if (start) pending <= 1'b1;
          if (rise_tick) begin
            shift_q <= shift_next[FRAME_BITS-2:0];
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
          if (frame_done) begin
            state        <= ST_QUIET;
            cs_n         <= 1'b1;
            sample       <= shift_next[DATA_BITS-1:0];
            sample_valid <= 1'b1;
            quiet_cnt    <= '0;
          end
        end
        ST_QUIET: begin
          if (start) pending <= 1'b1;
          if (quiet_done) begin
            // A start landing on the exit edge counts as pending.
            if (pending || start) begin
              state   <= ST_CONV;
              cs_n    <= 1'b0;
              pending <= 1'b0;
              bit_cnt <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (frame_done) begin
      frame_err <= |shift_next[FRAME_BITS-1 -: LEAD_BITS];
    end
  end
`else
  logic unused_lead;
  assign unused_lead = ^shift_next[FRAME_BITS-1 -: LEAD_BITS];
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler with HALF_DIV=2, QUIET_CYCLES=4 and a
// behavioural ADC that presents frame bits on each sclk falling edge.
module tb_adc_spi_sampler;
  import adc_spi_pkg::*;

  localparam int HALF_DIV     = 2;
  localparam int QUIET_CYCLES = 4;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 sdata;
  logic                 cs_n;
  logic                 sclk;
  logic [DATA_BITS-1:0] sample;
  logic                 sample_valid;
  logic                 busy;
  logic                 frame_err;
  adc_state_e           state_dbg;

  int compared   = 0;
  int mismatched = 0;

  adc_spi_sampler #(
    .HALF_DIV     (HALF_DIV),
    .QUIET_CYCLES (QUIET_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sdata        (sdata),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_err    (frame_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ADC model ----------------
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = '0;
  int          bit_idx   = 15;

  always @(negedge cs_n) begin
    bit_idx = 15;
    if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
    else cur_frame = '0;
  end

  always @(negedge sclk) begin
    if (cs_n === 1'b0 && bit_idx >= 0) begin
      sdata   = cur_frame[bit_idx];
      bit_idx = bit_idx - 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] got_q[$];
  logic [DATA_BITS-1:0] prev_sample = '0;
  logic                 prev_sclk   = 1'b1;
  int low_cnt   = 0;
  int rise_cnt  = 0;
  int valid_cnt = 0;
  int hold_err  = 0;

  always @(negedge clk) begin
    if (cs_n === 1'b0) low_cnt++;
    if (prev_sclk === 1'b0 && sclk === 1'b1) rise_cnt++;
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(sample);
    end
    if (rst === 1'b0 && sample_valid !== 1'b1 && sample !== prev_sample) hold_err++;
    prev_sclk   = sclk;
    prev_sample = sample;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    sdata = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cs_n !== 1'b1) begin mismatched++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    compared++;
    if (sclk !== 1'b1) begin mismatched++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
    compared++;
    if (sample !== 12'h000) begin mismatched++; $display("FAIL reset_sample got=%h exp=000", sample); end
    compared++;
    if (sample_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
    compared++;
    if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_single();
    bit ok;
    int v0;
    got_q.delete();
    frame_q.push_back(16'h0ABC);
    exp_q.push_back(12'hABC);
    low_cnt  = 0;
    rise_cnt = 0;
    v0 = valid_cnt;
    pulse_start();
    compared++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      mismatched++; $display("FAIL single_start_latency cs_n=%b busy=%b exp cs_n=0 busy=1", cs_n, busy);
    end
    wait_idle(300, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL single_timeout busy still high exp=0"); end
    compared++;
    if (low_cnt != 64) begin mismatched++; $display("FAIL single_cs_low got=%0d exp=64", low_cnt); end
    compared++;
    if (rise_cnt != 16) begin mismatched++; $display("FAIL single_sclk_rises got=%0d exp=16", rise_cnt); end
    compared++;
    if (valid_cnt - v0 != 1) begin mismatched++; $display("FAIL single_valid_pulses got=%0d exp=1", valid_cnt - v0); end
    while (exp_q.size() > 0) begin
      logic [DATA_BITS-1:0] e;
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL single_sample missing exp=%h", e); end
      else begin
        logic [DATA_BITS-1:0] g;
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL single_sample got=%h exp=%h", g, e); end
      end
    end
    compared++;
    if (frame_err !== 1'b0) begin mismatched++; $display("FAIL single_frame_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int v0;
    got_q.delete();
    frame_q.push_back(16'h0555);
    rise_cnt = 0;
    v0 = valid_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rise_cnt == 7) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL rst_mid_timeout rises=%0d exp=7", rise_cnt); end
    rst = 1'b1;
    #1;
    compared++;
    if (cs_n !== 1'b1 || sclk !== 1'b1) begin
      mismatched++; $display("FAIL rst_mid_pins cs_n=%b sclk=%b exp 1 1", cs_n, sclk);
    end
    compared++;
    if (sample !== 12'h000) begin mismatched++; $display("FAIL rst_mid_sample got=%h exp=000", sample); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    compared++;
    if (valid_cnt != v0) begin mismatched++; $display("FAIL rst_mid_no_valid got=%0d exp=%0d", valid_cnt, v0); end
    frame_q.push_back(16'h0DEF);
    exp_q.push_back(12'hDEF);
    pulse_start();
    wait_idle(300, ok);
    compared++;
    if (!ok || valid_cnt - v0 != 1) begin
      mismatched++; $display("FAIL rst_mid_recover pulses=%0d exp=1", valid_cnt - v0);
    end
    while (exp_q.size() > 0) begin
      logic [DATA_BITS-1:0] e;
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL rst_mid_sample missing exp=%h", e); end
      else begin
        logic [DATA_BITS-1:0] g;
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL rst_mid_sample got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int v0;
    int n;
    got_q.delete();
    frame_q.push_back(16'h0123);
    frame_q.push_back(16'h0456);
    exp_q.push_back(12'h123);
    exp_q.push_back(12'h456);
    low_cnt = 0;
    v0 = valid_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_valid(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL b2b_first_valid_timeout exp=valid"); end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (cs_n === 1'b0) break;
    end
    compared++;
    if (n != QUIET_CYCLES) begin mismatched++; $display("FAIL b2b_quiet_gap got=%0d exp=%0d", n, QUIET_CYCLES); end
    wait_idle(400, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL b2b_idle_timeout busy still high exp=0"); end
    repeat (150) @(negedge clk);
    compared++;
    if (valid_cnt - v0 != 2) begin mismatched++; $display("FAIL b2b_valid_pulses got=%0d exp=2", valid_cnt - v0); end
    compared++;
    if (low_cnt != 128) begin mismatched++; $display("FAIL b2b_cs_low got=%0d exp=128", low_cnt); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_third_dropped busy=%b exp=0", busy); end
    while (exp_q.size() > 0) begin
      logic [DATA_BITS-1:0] e;
      e = exp_q.pop_front();
      compared++;
      if (got_q.size() == 0) begin mismatched++; $display("FAIL b2b_sample missing exp=%h", e); end
      else begin
        logic [DATA_BITS-1:0] g;
        g = got_q.pop_front();
        if (g !== e) begin mismatched++; $display("FAIL b2b_sample got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_extremes();
    bit ok;
    hold_err = 0;
    got_q.delete();
    frame_q.push_back(16'h0FFF);
    pulse_start();
    wait_idle(300, ok);
    repeat (20) @(negedge clk);
    compared++;
    if (!ok || sample !== 12'hFFF) begin mismatched++; $display("FAIL ext_all_ones got=%h exp=fff", sample); end
    frame_q.push_back(16'h0000);
    pulse_start();
    wait_idle(300, ok);
    compared++;
    if (!ok || sample !== 12'h000) begin mismatched++; $display("FAIL ext_all_zeros got=%h exp=000", sample); end
    compared++;
    if (got_q.size() != 2) begin mismatched++; $display("FAIL ext_pulses got=%0d exp=2", got_q.size()); end
    compared++;
    if (hold_err != 0) begin mismatched++; $display("FAIL ext_sample_hold changes=%0d exp=0", hold_err); end
  endtask

  task automatic test_idle();
    int bad;
    int v0;
    bad = 0;
    v0  = valid_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL idle_pins bad_cycles=%0d exp=0", bad); end
    compared++;
    if (valid_cnt != v0) begin mismatched++; $display("FAIL idle_valid got=%0d exp=%0d", valid_cnt, v0); end
  endtask

  task automatic test_frame_check();
    bit ok;
    logic exp_err;
`ifdef ADC_FRAME_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    frame_q.push_back(16'h8ABC);
    pulse_start();
    wait_idle(300, ok);
    compared++;
    if (!ok || sample !== 12'hABC) begin mismatched++; $display("FAIL fchk_bad_sample got=%h exp=abc", sample); end
    compared++;
    if (frame_err !== exp_err) begin mismatched++; $display("FAIL fchk_bad_err got=%b exp=%b", frame_err, exp_err); end
    frame_q.push_back(16'h0123);
    pulse_start();
    wait_idle(300, ok);
    compared++;
    if (!ok || sample !== 12'h123) begin mismatched++; $display("FAIL fchk_good_sample got=%h exp=123", sample); end
    compared++;
    if (frame_err !== 1'b0) begin mismatched++; $display("FAIL fchk_good_err got=%b exp=0", frame_err); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_reset_mid_frame();
    test_back_to_back();
    test_extremes();
    test_idle();
    test_frame_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
